// File: rtl/simm_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the SIMM arbiter and the SIMM controller.
// The slave modport is the arbiter's view; master is the requester/controller side.
interface simm_arbiter_if;
    logic       cpu_req;
    logic       cpu_write;
    logic       cpu_bank;
    logic [3:0] cpu_be;
    logic       cpu_ack;

    logic       dma_req;
    logic       dma_write;
    logic       dma_bank;
    logic [3:0] dma_be;
    logic       dma_ack;

    logic       mem_cs;
    logic       mem_read;
    logic       mem_write;
    logic       mem_bank_addr;
    logic [3:0] mem_byte_selects;
    logic       mem_waitstate;

    logic       grant_dma;

    modport slave (
        input  cpu_req, cpu_write, cpu_bank, cpu_be,
        input  dma_req, dma_write, dma_bank, dma_be,
        input  mem_waitstate,
        output cpu_ack, dma_ack,
        output mem_cs, mem_read, mem_write, mem_bank_addr, mem_byte_selects,
        output grant_dma
    );

    modport master (
        output cpu_req, cpu_write, cpu_bank, cpu_be,
        output dma_req, dma_write, dma_bank, dma_be,
        output mem_waitstate,
        input  cpu_ack, dma_ack,
        input  mem_cs, mem_read, mem_write, mem_bank_addr, mem_byte_selects,
        input  grant_dma
    );
endinterface

// File: rtl/simm_arbiter.sv
// CPU/DMA arbiter for a single SIMM controller: CPU priority with a starvation
// counter that forces a DMA grant after STARVE_LIMIT consecutive contested CPU grants.
module simm_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clock,
    input  logic           reset,
    simm_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic          first_cyc, first_nxt;
    logic          grant_q, grant_nxt;
    logic          lat_write, write_nxt;
    logic          lat_bank, bank_nxt;
    logic [3:0]    lat_be, be_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;
    logic          dma_win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            first_cyc  <= 1'b0;
            grant_q    <= 1'b0;
            lat_write  <= 1'b0;
            lat_bank   <= 1'b0;
            lat_be     <= 4'b0000;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            first_cyc  <= first_nxt;
            grant_q    <= grant_nxt;
            lat_write  <= write_nxt;
            lat_bank   <= bank_nxt;
            lat_be     <= be_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        first_nxt  = first_cyc;
        grant_nxt  = grant_q;
        write_nxt  = lat_write;
        bank_nxt   = lat_bank;
        be_nxt     = lat_be;
        starve_nxt = starve_cnt;
        dma_win    = bus.dma_req && (!bus.cpu_req || starve_cnt == STARVE_MAX);

        bus.mem_cs           = 1'b0;
        bus.mem_read         = 1'b0;
        bus.mem_write        = 1'b0;
        bus.mem_bank_addr    = 1'b0;
        bus.mem_byte_selects = 4'b0000;
        bus.cpu_ack          = 1'b0;
        bus.dma_ack          = 1'b0;
        bus.grant_dma        = grant_q;

        unique case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    state_nxt = ACCESS;
                    first_nxt = 1'b1;
                    grant_nxt = dma_win;
                    write_nxt = dma_win ? bus.dma_write : bus.cpu_write;
                    bank_nxt  = dma_win ? bus.dma_bank  : bus.cpu_bank;
                    be_nxt    = dma_win ? bus.dma_be    : bus.cpu_be;
                    // Only a CPU grant that made DMA wait counts toward starvation.
                    if (dma_win || !bus.dma_req)
                        starve_nxt = '0;
                    else if (starve_cnt != STARVE_MAX)
                        starve_nxt = starve_cnt + 1'b1;
                end else begin
                    starve_nxt = '0;
                end
            end
            ACCESS: begin
                bus.mem_cs           = 1'b1;
                bus.mem_read         = ~lat_write;
                bus.mem_write        = lat_write;
                bus.mem_bank_addr    = lat_bank;
                bus.mem_byte_selects = lat_be;
                first_nxt            = 1'b0;
                // Waitstate in the first cycle is stale when the controller registers it.
                if (!first_cyc && !bus.mem_waitstate)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.cpu_ack = ~grant_q;
                bus.dma_ack = grant_q;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_simm_arbiter.sv
// Directed bench for simm_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for latency, grant order, attribute hold and reset.
module tb_simm_arbiter;
    localparam int LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    simm_arbiter_if bus();

    simm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_acc counts cycles spent in the current access (0 = none in flight),
    // m_ack_due marks the single completion cycle.
    int       m_acc = 0;
    int       m_starve = 0;
    bit       m_ack_due = 1'b0;
    bit       m_dma = 1'b0;
    bit       m_we = 1'b0;
    bit       m_bank = 1'b0;
    bit [3:0] m_be = 4'b0000;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_acc = 0; m_starve = 0; m_ack_due = 1'b0;
            m_dma = 1'b0; m_we = 1'b0; m_bank = 1'b0; m_be = 4'b0000;
        end else if (m_ack_due) begin
            m_ack_due = 1'b0;
        end else if (m_acc > 0) begin
            if (m_acc >= 2 && !bus.mem_waitstate) begin
                m_acc = 0;
                m_ack_due = 1'b1;
            end else begin
                m_acc++;
            end
        end else if (bus.cpu_req || bus.dma_req) begin
            m_dma  = bus.dma_req && (!bus.cpu_req || m_starve == LIMIT);
            m_we   = m_dma ? bus.dma_write : bus.cpu_write;
            m_bank = m_dma ? bus.dma_bank  : bus.cpu_bank;
            m_be   = m_dma ? bus.dma_be    : bus.cpu_be;
            if (m_dma || !bus.dma_req) m_starve = 0;
            else m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            m_acc = 1;
        end else begin
            m_starve = 0;
        end
    end

    bit prev_cs = 1'b0;
    bit dut_grants[$];
    int acc_len = 0;
    int last_len = 0;
    int cpu_acks = 0;
    int dma_acks = 0;

    always @(negedge clock) begin
        chk("mem_cs",    bus.mem_cs,           32'(m_acc > 0));
        chk("mem_read",  bus.mem_read,         32'((m_acc > 0) && !m_we));
        chk("mem_write", bus.mem_write,        32'((m_acc > 0) && m_we));
        chk("mem_bank",  bus.mem_bank_addr,    32'((m_acc > 0) ? m_bank : 1'b0));
        chk("mem_be",    bus.mem_byte_selects, 32'((m_acc > 0) ? m_be : 4'b0000));
        chk("grant_dma", bus.grant_dma,        32'(m_dma));
        chk("cpu_ack",   bus.cpu_ack,          32'(m_ack_due && !m_dma));
        chk("dma_ack",   bus.dma_ack,          32'(m_ack_due && m_dma));
        if (bus.mem_cs && !prev_cs) dut_grants.push_back(bus.grant_dma);
        if (bus.mem_cs) acc_len++;
        else if (prev_cs) begin
            last_len = acc_len;
            acc_len  = 0;
        end
        prev_cs = bus.mem_cs;
        if (bus.cpu_ack) cpu_acks++;
        if (bus.dma_ack) dma_acks++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for the ack pulse, then release requests on the edge that samples it.
    task automatic wait_done(input string name);
        int n = 0;
        while (!(bus.cpu_ack || bus.dma_ack) && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_ack_seen"}, 32'(n < 100), 32'd1);
        tick();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        bus.mem_waitstate = 1'b1;
    endtask

    bit exp_order[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int c0, d0, n;
        bus.cpu_req = 1'b0; bus.cpu_write = 1'b0; bus.cpu_bank = 1'b0; bus.cpu_be = 4'b0000;
        bus.dma_req = 1'b0; bus.dma_write = 1'b0; bus.dma_bank = 1'b0; bus.dma_be = 4'b0000;
        bus.mem_waitstate = 1'b1;

        // Reset state, with a request already pending that must not be granted yet
        bus.cpu_req = 1'b1;
        repeat (2) tick();
        chk("rst_cs", bus.mem_cs, 0);
        chk("rst_be", bus.mem_byte_selects, 0);
        chk("rst_grant", bus.grant_dma, 0);
        chk("rst_acks", {bus.cpu_ack, bus.dma_ack}, 0);
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("post_rst_cs", bus.mem_cs, 0);

        // CPU read, waitstate held 4 cycles after cs
        c0 = cpu_acks; d0 = dma_acks;
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_bank = 1'b0; bus.cpu_be = 4'b0011;
        tick();
        chk("rd_cs_latency", bus.mem_cs, 1);
        chk("rd_read", bus.mem_read, 1);
        chk("rd_be", bus.mem_byte_selects, 4'b0011);
        chk("rd_grant", bus.grant_dma, 0);
        repeat (4) tick();
        bus.mem_waitstate = 1'b0;
        wait_done("rd");
        repeat (2) tick();
        chk("rd_cpu_acks", cpu_acks - c0, 1);
        chk("rd_dma_acks", dma_acks - d0, 0);

        // DMA write alone, waitstate low from the start
        c0 = cpu_acks; d0 = dma_acks;
        bus.dma_req = 1'b1; bus.dma_write = 1'b1; bus.dma_bank = 1'b1; bus.dma_be = 4'b1111;
        bus.mem_waitstate = 1'b0;
        tick();
        chk("dw_write", bus.mem_write, 1);
        chk("dw_bank", bus.mem_bank_addr, 1);
        chk("dw_grant", bus.grant_dma, 1);
        wait_done("dw");
        repeat (2) tick();
        chk("dw_dma_acks", dma_acks - d0, 1);
        chk("dw_cpu_acks", cpu_acks - c0, 0);
        chk("dw_access_len", last_len, 2);

        // Waitstate 0 in the first access cycle is ignored: exactly two cycles
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_bank = 1'b0; bus.cpu_be = 4'b0101;
        bus.mem_waitstate = 1'b0;
        wait_done("ws0");
        repeat (2) tick();
        chk("ws0_access_len", last_len, 2);

        // Attributes change mid-access; latched values must hold
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_bank = 1'b0; bus.cpu_be = 4'b0011;
        bus.mem_waitstate = 1'b1;
        repeat (2) tick();
        bus.cpu_be = 4'b1100; bus.cpu_write = 1'b1; bus.cpu_bank = 1'b1;
        tick();
        chk("attr_be_held", bus.mem_byte_selects, 4'b0011);
        chk("attr_read_held", bus.mem_read, 1);
        chk("attr_bank_held", bus.mem_bank_addr, 0);
        bus.mem_waitstate = 1'b0;
        wait_done("attr");
        repeat (2) tick();

        // Both requesters held: starvation limit forces the fifth grant to DMA
        c0 = cpu_acks; d0 = dma_acks;
        dut_grants.delete();
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_be = 4'b0001;
        bus.dma_req = 1'b1; bus.dma_write = 1'b1; bus.dma_be = 4'b1000;
        bus.mem_waitstate = 1'b0;
        n = 0;
        while (dut_grants.size() < 6 && n < 200) begin
            tick();
            n++;
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        repeat (6) tick();
        chk("order_count", 32'(dut_grants.size() >= 6), 1);
        for (int i = 0; i < 6 && i < dut_grants.size(); i++)
            chk($sformatf("order_grant%0d", i), dut_grants[i], exp_order[i]);
        chk("order_cpu_acks", cpu_acks - c0, 5);
        chk("order_dma_acks", dma_acks - d0, 1);

        // Reset in the middle of a stalled access
        c0 = cpu_acks; d0 = dma_acks;
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b0; bus.cpu_be = 4'b0011;
        bus.mem_waitstate = 1'b1;
        repeat (2) tick();
        chk("mid_cs_before", bus.mem_cs, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_cs_async", bus.mem_cs, 0);
        chk("mid_be_async", bus.mem_byte_selects, 0);
        bus.cpu_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        chk("mid_cs_release", bus.mem_cs, 0);
        repeat (3) tick();
        chk("mid_no_cpu_ack", cpu_acks - c0, 0);
        chk("mid_no_dma_ack", dma_acks - d0, 0);

        // Fresh CPU request after reset release
        c0 = cpu_acks;
        bus.cpu_req = 1'b1; bus.cpu_write = 1'b1; bus.cpu_bank = 1'b1; bus.cpu_be = 4'b1001;
        tick();
        chk("fresh_cs", bus.mem_cs, 1);
        chk("fresh_be", bus.mem_byte_selects, 4'b1001);
        repeat (2) tick();
        bus.mem_waitstate = 1'b0;
        wait_done("fresh");
        repeat (2) tick();
        chk("fresh_cpu_ack", cpu_acks - c0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/simm_arbiter.md
SIMM_ARBITER -- requirements
Module: simm_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive CPU grants allowed while dma_req is pending before DMA is forced.
REQ-002 clock  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 = reset asserted.
REQ-004 cpu_req / cpu_write / cpu_bank / cpu_be  in  1/1/1/4  CPU access request, direction (1=write), bank select, byte enables.
REQ-005 cpu_ack  out  1  one-cycle pulse when the CPU access completes.
REQ-006 dma_req / dma_write / dma_bank / dma_be  in  1/1/1/4  DMA access request, same meanings as the CPU inputs.
REQ-007 dma_ack  out  1  one-cycle pulse when the DMA access completes.
REQ-008 mem_cs / mem_read / mem_write / mem_bank_addr  out  1/1/1/1  command to the SIMM controller.
REQ-009 mem_byte_selects  out  4  byte selects to the SIMM controller.
REQ-010 mem_waitstate  in  1  SIMM controller busy; 0 = access finished.
REQ-011 grant_dma  out  1  address-mux steer: 1 = DMA owns the address path, 0 = CPU owns it.

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS and DONE; the reset state SHALL be IDLE.
REQ-013 IDLE: if any req=1 at a rising edge, arbitrate, latch the winner's write, bank and byte enables into registers, and go to ACCESS; otherwise stay in IDLE.
REQ-014 Arbitration: CPU wins over DMA, except that DMA wins when both request and starve_cnt equals STARVE_LIMIT.
REQ-015 starve_cnt: increments on each CPU grant made while dma_req=1; clears on any DMA grant and whenever dma_req=0 in IDLE; saturates at STARVE_LIMIT.
REQ-016 grant_dma SHALL update only on the IDLE->ACCESS edge and hold its value through ACCESS and DONE.
REQ-017 ACCESS outputs: mem_cs=1, mem_read=~latched write, mem_write=latched write; mem_bank_addr and mem_byte_selects come from the latched registers and stay stable for the whole ACCESS state.
REQ-018 Latency: mem_cs SHALL assert in the cycle immediately after the edge that samples req in IDLE.
REQ-019 Completion: the first rising edge in ACCESS, excluding the first ACCESS cycle, with mem_waitstate=0 SHALL move the FSM to DONE; the first-cycle waitstate value is ignored so that a registered waitstate is tolerated.
REQ-020 DONE lasts exactly one cycle: mem_cs/read/write=0, the owner's ack=1, then go to IDLE; the other ack SHALL stay 0.
REQ-021 Requesters hold req and attributes until ack and deassert req on the edge at which ack=1 is sampled; the arbiter SHALL NOT re-sample req in DONE.
REQ-022 A req dropped mid-ACCESS SHALL NOT abort the access; it completes and ack still pulses.
REQ-023 Attribute changes during ACCESS SHALL NOT affect mem_* outputs.
REQ-024 Minimum spacing between accesses is one IDLE cycle; back-to-back accesses take ACCESS + DONE + IDLE per transfer.
REQ-025 If mem_waitstate stays 1 indefinitely, the FSM SHALL remain in ACCESS with no timeout.

Reset
REQ-026 On reset=0, the FSM SHALL go to IDLE immediately and asynchronously; mem_cs, mem_read, mem_write, mem_bank_addr, grant_dma, cpu_ack and dma_ack SHALL be 0, mem_byte_selects=4'b0000 and starve_cnt=0.
REQ-027 Reset asserted during ACCESS SHALL drop mem_cs without waiting for mem_waitstate and SHALL issue no ack.
REQ-028 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-029 CPU read: cpu_req=1, write=0, be=4'b0011, waitstate low 4 cycles after cs -> mem_cs=1 next cycle, mem_read=1, mem_byte_selects=0011, grant_dma=0, one cpu_ack pulse, dma_ack=0.
REQ-030 Simultaneous requests, STARVE_LIMIT=4: CPU and DMA both held continuously -> grant order CPU,CPU,CPU,CPU,DMA, then CPU again.
REQ-031 DMA write alone: dma_req=1, write=1, bank=1, be=4'b1111 -> mem_write=1, mem_bank_addr=1, grant_dma=1, one dma_ack pulse.
REQ-032 Attributes toggled mid-access: cpu_be changed 0011->1100 during ACCESS -> mem_byte_selects stays 0011 until DONE.
REQ-033 Reset mid-ACCESS: reset=0 while mem_waitstate=1 -> mem_cs=0 at once, no ack; after release, a fresh cpu_req is served normally.
REQ-034 Waitstate already 0 in the first ACCESS cycle -> that cycle is ignored; DONE is entered after exactly two ACCESS cycles.
